reorder_buffer: RTL

- In-order commit stage directly downstream of the CDB in the Tomasulo core.
- Allocates one entry per issued instruction in program order and captures results broadcast on the 16-bit CDB.
- Retires completed entries strictly in order, producing one register write per cycle for the register bank.
- Sits between the reservation-station/ULA/CDB pipeline and the architectural register write port.

---
 rtl/tomasulo_pkg.sv | 29 ++
 rtl/rob_oldest_match.sv | 29 ++
 rtl/reorder_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: CDB field layout, one-hot register codes,
// unit encodings and the reorder-buffer entry record.
package tomasulo_pkg;

  localparam int DEST_HI    = 15;
  localparam int DEST_LO    = 13;
  localparam int POS_HI     = 12;
  localparam int POS_LO     = 11;
  localparam int UNIT_BIT   = 10;
  localparam int DATA_HI    = 9;
  localparam int CDB_DATA_W = DATA_HI + 1;

  localparam logic [2:0] REG_R0   = 3'b100;
  localparam logic [2:0] REG_R1   = 3'b010;
  localparam logic [2:0] REG_R2   = 3'b001;
  localparam logic [2:0] REG_NONE = 3'b000;

  localparam logic UNIT_ULA  = 1'b1;
  localparam logic UNIT_LDSD = 1'b0;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [2:0]            rs_tag;
    logic [2:0]            dest;
    logic [CDB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_oldest_match.sv
// Rotate-priority encoder: finds the matching entry closest to head,
// walking forward from head in program order.
module rob_oldest_match #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [DEPTH-1:0] match,
  input  logic [IDX_W-1:0] head,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Scan youngest-to-oldest so the last hit written is the oldest one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      pos = head + IDX_W'(k);
      if (match[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit stage behind the CDB: allocates in program order, captures
// CDB results, retires one entry per cycle. ROB_FLUSH_EN adds a 'flush' input.
module reorder_buffer
  import tomasulo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [2:0]        issue_rs_tag,
  input  logic [2:0]        issue_dest,
  output logic              issue_ready,
  output logic [IDX_W-1:0]  issue_idx,
  input  logic [15:0]       cdb,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  output logic              commit_valid,
  output logic [2:0]        commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [IDX_W-1:0]  commit_idx,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
);

  rob_entry_t rob [DEPTH];

  logic [IDX_W-1:0]      head;
  logic [IDX_W-1:0]      tail;
  logic                  cdb_valid;
  logic [2:0]            cdb_tag;
  logic [CDB_DATA_W-1:0] cdb_data;
  logic [DEPTH-1:0]      match;
  logic                  older_found;
  logic [IDX_W-1:0]      older_idx;
  logic                  do_alloc;
  logic                  new_pending;
  logic                  new_capture;
  logic                  do_commit;
  logic                  flush_req;
  logic [IDX_W:0]        count_next;

`ifdef ROB_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign cdb_valid = |cdb[DEST_HI:DEST_LO];
  assign cdb_tag   = {cdb[UNIT_BIT], cdb[POS_HI:POS_LO]};
  assign cdb_data  = cdb[DATA_HI:0];

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = cdb_valid && rob[i].busy && !rob[i].done && (rob[i].rs_tag == cdb_tag);
    end
  end

  rob_oldest_match #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_oldest (
    .match (match),
    .head  (head),
    .found (older_found),
    .idx   (older_idx)
  );

  assign issue_ready = !full;
  assign issue_idx   = tail;
  assign do_alloc    = issue_valid && !full;
  assign do_commit   = rob[head].busy && rob[head].done;
  assign new_pending = (issue_dest != REG_NONE);
  // A freshly issued entry may take the broadcast only if nothing older wants it.
  assign new_capture = do_alloc && new_pending && cdb_valid &&
                       (issue_rs_tag == cdb_tag) && !older_found;
  assign count_next  = count + {{IDX_W{1'b0}}, do_alloc} - {{IDX_W{1'b0}}, do_commit};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      commit_valid <= 1'b0;
      commit_dest  <= '0;
      commit_data  <= '0;
      commit_idx   <= '0;
    end else if (flush_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob[i].busy <= 1'b0;
        rob[i].done <= 1'b0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      commit_valid <= 1'b0;
    end else begin
      commit_valid <= do_commit;
      if (do_commit) begin
        commit_dest     <= rob[head].dest;
        commit_data     <= DATA_W'(rob[head].data);
        commit_idx      <= head;
        rob[head].busy  <= 1'b0;
        rob[head].done  <= 1'b0;
        head            <= head + 1'b1;
      end
      if (older_found) begin
        rob[older_idx].done <= 1'b1;
        rob[older_idx].data <= cdb_data;
      end
      if (do_alloc) begin
        rob[tail] <= '{busy:   1'b1,
                       done:   !new_pending || new_capture,
                       rs_tag: issue_rs_tag,
                       dest:   issue_dest,
                       data:   new_capture ? cdb_data : '0};
        tail <= tail + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == (IDX_W+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule
